// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// Handshake: a start is taken on a rising edge only when start=1 and ready=1;
// a/b/cin are captured on that same edge. done is a one-cycle pulse, and
// sum/cout are valid from the done cycle until the next operation completes.
interface serial_adder_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side: drives operands and start, observes status and result.
    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout
    );

    // Adder side: consumes operands, drives status and result.
    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout, sum} = a + b + cin computed LSB first over WIDTH
// cycles through one full-adder cell and a carry flip-flop. Subtraction is
// a + ~b + 1. The FSM state is exposed on dbg_state_o for checkers.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_if.slave        bus_if,
    output logic [1:0]           dbg_state_o
);

    // Counter holds bit index 0..WIDTH-1; clog2(WIDTH) bits reach WIDTH-1
    // without wrapping before the last bit is processed.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             ready_w;
    logic             accept_w;
    logic             s_bit_w;
    logic             c_next_w;
    logic [WIDTH-1:0] res_next_w;

    // Full-adder cell on the current LSBs and the carry flip-flop.
    always_comb begin
        s_bit_w    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        c_next_w   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) |
                     (b_sh_q[0] & carry_q);
        res_next_w = {s_bit_w, res_q[WIDTH-1:1]};
    end

    // A new operation may be accepted in IDLE and, back-to-back, in DONE.
    always_comb begin
        ready_w  = (state_q == S_IDLE) || (state_q == S_DONE);
        accept_w = ready_w && bus_if.start;
    end

    // Next-state and datapath control; every target holds by default.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_w) begin
                    // Capture operands; cin seeds the carry flip-flop.
                    a_sh_d  = bus_if.a;
                    b_sh_d  = bus_if.b;
                    carry_d = bus_if.cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                // One bit per edge: result fills from the MSB side so the
                // LSB lands in bit 0 after WIDTH shifts.
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_next_w;
                carry_d = c_next_w;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Result registers change only on the completion edge.
                    sum_d   = res_next_w;
                    cout_d  = c_next_w;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Status decoded from state; result driven straight from registers.
    assign bus_if.ready = ready_w;
    assign bus_if.busy  = (state_q == S_SHIFT);
    assign bus_if.done  = (state_q == S_DONE);
    assign bus_if.sum   = sum_q;
    assign bus_if.cout  = cout_q;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, multi-cycle adder: computes sum = a + b + cin over WIDTH clock cycles, LSB first, through a single full-adder cell and a carry flip-flop.
- It is the additive counterpart of the team's combinational 4-bit subtraction block. Subtraction a - b is obtained by driving b with ~b_orig and cin with 1.
- It sits in the datapath wherever area matters more than latency. Operands are loaded with a start pulse, and the result is reported with a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  load request; sampled only when ready.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- ready  output  1  high when a start will be accepted (state IDLE or DONE).
- busy  output  1  high while bits are being processed (state SHIFT).
- done  output  1  one-cycle pulse; sum/cout valid from this cycle on.
- sum  output  WIDTH  registered result; holds until the next accepted start completes.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Reset: synchronous, active-low. When rst_n=0 at a rising edge:
  - state=IDLE; ready=1; busy=0; done=0; sum=0; cout=0.
  - Internal operand shift registers, bit counter and carry flip-flop clear to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge: latch a, b and cin into the carry FF; clear bit counter; go to SHIFT.
- SHIFT:
  - busy=1, ready=0.
  - Each edge processes bit i = counter:
    - s_i = a_sh[0] ^ b_sh[0] ^ c.
    - c <= majority(a_sh[0], b_sh[0], c).
    - Shift s_i into the result shift register from the MSB side.
    - Shift a_sh and b_sh right by 1; counter++.
  - The edge processing bit WIDTH-1 also copies the completed result into sum, copies the final carry into cout, and moves to DONE.
- DONE:
  - done=1 and ready=1 for this one cycle.
  - start=1 at this edge: accepted exactly as in IDLE (back-to-back) and goes to SHIFT.
  - Otherwise go to IDLE.
- Latency: start accepted at edge k → SHIFT during cycles k..k+WIDTH-1 → sum/cout update and done=1 after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1: ignored; operands are not re-latched and the operation in flight is unaffected.
- Input changes on a/b/cin after acceptance: no effect on the result.
- sum/cout change only on the completion edge. They are stable during SHIFT, showing the previous result.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- Reset during SHIFT: the operation is aborted, all outputs return to reset values, and no done pulse is produced.
- The counter width is clog2(WIDTH). The counter must not wrap before the last bit is processed.

Test Plan (WIDTH=4):
- Reset: hold rst_n=0 for 2 cycles with start=1 → ready=1, busy=0, done=0, sum=0000, cout=0; no operation starts.
- Basic add: a=0110, b=0011, cin=0, one-cycle start → busy high 4 cycles; done pulse on the 5th cycle after acceptance; sum=1001, cout=0.
- Subtraction use: a=0110, b=1100 (~0011), cin=1 → sum=0011, cout=1. Then a=0111, b=1110, cin=1 → sum=0110, cout=1.
- Wrap/carry boundary: a=1111, b=0001, cin=0 → sum=0000, cout=1. Then a=1111, b=1111, cin=1 → sum=1111, cout=1.
- Handshake:
  - Pulse start mid-SHIFT with new operands → ignored; the first result is unchanged and exactly one done pulse is produced.
  - Assert start during the done cycle (a=0010, b=1001, cin=0) → accepted; done recurs exactly 5 cycles later with sum=1011, cout=0.
- Reset mid-operation: drop rst_n during the 2nd SHIFT cycle → next edge sum=0, cout=0, busy=0, no done pulse. A subsequent start yields the correct result.
